// File: rtl/fpu_result_stage.sv
// fpu_result_stage: formats FPU results and exceptions into a 2-entry FIFO with sticky flags and an exception counter
// Ports: CLK/RST clock and sync active-high reset; IN_VALID/IN_READY input handshake;
//   FP_OPERATION, OP_A, OP_B, ARITH_RESULT, OP_IS_EXCEPTION, FP_EXCE incoming result and exception info;
//   OUT_VALID/OUT_READY output handshake; RESULT, RESULT_EXCE head entry;
//   STATUS_FLAGS sticky flags cleared by FLAGS_CLR; EXCE_COUNT saturating exception count
module fpu_result_stage #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] QNAN_VAL = 8'h7C,
  parameter logic [6:0] INF_MAG  = 7'h78
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [1:0] FP_OPERATION,
  input  logic [7:0] OP_A,
  input  logic [7:0] OP_B,
  input  logic [7:0] ARITH_RESULT,
  input  logic       OP_IS_EXCEPTION,
  input  logic [2:0] FP_EXCE,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] RESULT,
  output logic [2:0] RESULT_EXCE,
  output logic [3:0] STATUS_FLAGS,
  input  logic       FLAGS_CLR,
  output logic [7:0] EXCE_COUNT
);
  logic [1:0] r_cnt;
  logic       r_wp, r_rp;
  logic [7:0] r_data [2];
  logic [2:0] r_exce [2];
  logic [3:0] r_flags;
  logic [7:0] r_ecnt;
  logic       w_acc, w_pop, w_exc, w_head;
  logic [7:0] w_res;
  logic [2:0] w_code;
  logic [3:0] w_set;
  logic [1:0] w_unused_op;
  assign w_unused_op = FP_OPERATION;
  assign IN_READY  = r_cnt < 2'(DEPTH);
  assign OUT_VALID = r_cnt != 2'd0;
  assign w_acc     = IN_VALID && IN_READY;
  assign w_pop     = OUT_VALID && OUT_READY;
  assign w_exc     = OP_IS_EXCEPTION && FP_EXCE != 3'd0;
  assign w_res     = !w_exc ? ARITH_RESULT : FP_EXCE == 3'd3 ? {OP_A[7] ^ OP_B[7], INF_MAG} : QNAN_VAL;
  assign w_code    = w_exc ? FP_EXCE : 3'd0;
  assign w_set     = w_acc && w_exc ? {FP_EXCE[2], FP_EXCE == 3'd3, FP_EXCE == 3'd2, FP_EXCE == 3'd1} : 4'd0;
  // When empty, the read pointer has already moved past the last popped entry; look back so outputs hold.
  assign w_head       = OUT_VALID ? r_rp : ~r_rp;
  assign RESULT       = r_data[w_head];
  assign RESULT_EXCE  = r_exce[w_head];
  assign STATUS_FLAGS = r_flags;
  assign EXCE_COUNT   = r_ecnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= 2'd0;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_data  <= '{8'd0, 8'd0};
      r_exce  <= '{3'd0, 3'd0};
      r_flags <= 4'd0;
      r_ecnt  <= 8'd0;
    end else begin
      if (w_acc) begin
        r_data[r_wp] <= w_res;
        r_exce[r_wp] <= w_code;
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt   <= r_cnt + {1'b0, w_acc} - {1'b0, w_pop};
      r_flags <= (FLAGS_CLR ? 4'd0 : r_flags) | w_set;
      r_ecnt  <= r_ecnt + {7'd0, w_acc && w_exc && r_ecnt != 8'hFF};
    end
  end
endmodule
